fpu_ss_offload_buffer: RTL

FPU_SS_OFFLOAD_BUFFER -- requirements
Module: fpu_ss_offload_buffer

---
 rtl/fpu_ss_offload_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fpu_ss_offload_buffer.sv
// FPU subsystem offload buffer: takes offloaded instructions from the core,
// sends a registered accept/writeback response, and queues accepted
// instructions with their rs1 operand for the FPU decoder.
module fpu_ss_offload_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    // Offload request from the core
    input  logic                       q_valid_i,
    output logic                       q_ready_o,
    input  logic [DATA_W-1:0]          q_instr_i,
    input  logic [DATA_W-1:0]          q_rs1_i,
    input  logic                       q_rs1_valid_i,
    // Predecoder result for q_instr_i
    input  logic                       prd_accept_i,
    input  logic                       prd_writeback_i,
    input  logic                       prd_is_mem_op_i,
    input  logic [2:0]                 prd_use_rs_i,
    // Response to the core
    output logic                       k_valid_o,
    output logic                       k_accept_o,
    output logic                       k_writeback_o,
    // Head entry towards the decoder
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_instr_o,
    output logic [DATA_W-1:0]          out_rs1_o,
    output logic                       out_writeback_o,
    output logic                       out_is_mem_op_o,
    // Control and status
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Payload storage; validity is tracked only by the pointers and count
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [DATA_W-1:0] rs1_mem   [DEPTH];
    logic [DEPTH-1:0]  wb_mem;
    logic [DEPTH-1:0]  memop_mem;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             k_valid_q, k_accept_q, k_writeback_q;

    logic             operands_ok;
    logic             taken;
    logic             push;
    logic             pop;

    // Only the rs1 use flag matters here; rs2/rs3 come from the FPU regfile
    logic             unused_use_rs;
    assign unused_use_rs = ^prd_use_rs_i[2:1];

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Readiness depends only on the registered occupancy, never on out_ready_i,
    // so a pop in the same cycle cannot open a slot for a push at full.
    assign operands_ok = !prd_use_rs_i[0] || q_rs1_valid_i;
    assign q_ready_o   = !rst_i && !flush_i &&
                         (!prd_accept_i || (!full_o && operands_ok));
    assign taken       = q_valid_i && q_ready_o;
    assign push        = taken && prd_accept_i;

    assign out_valid_o     = !empty_o && !rst_i;
    assign pop             = out_valid_o && out_ready_i;
    assign out_instr_o     = instr_mem[rd_ptr_q];
    assign out_rs1_o       = rs1_mem[rd_ptr_q];
    assign out_writeback_o = wb_mem[rd_ptr_q];
    assign out_is_mem_op_o = memop_mem[rd_ptr_q];

    assign k_valid_o     = k_valid_q;
    assign k_accept_o    = k_accept_q;
    assign k_writeback_o = k_writeback_q;

    // Next pointer/occupancy; flush discards everything regardless of push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state and the one-cycle response to each taken request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            k_valid_q     <= 1'b0;
            k_accept_q    <= 1'b0;
            k_writeback_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            k_valid_q     <= taken;
            k_accept_q    <= taken && prd_accept_i;
            k_writeback_q <= taken && prd_accept_i && prd_writeback_i;
        end
    end

    // Payload write at the tail; rs1 is zeroed when the instruction ignores it
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= q_instr_i;
            rs1_mem[wr_ptr_q]   <= prd_use_rs_i[0] ? q_rs1_i : '0;
            wb_mem[wr_ptr_q]    <= prd_writeback_i;
            memop_mem[wr_ptr_q] <= prd_is_mem_op_i;
        end
    end

endmodule
